scan_decoder: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder.
- Two modes:
  - Direct: decodes a presented select value.
  - Scan: autonomously walks the one-hot output across all 2^N lines, holding each line for a programmable dwell.
- Used for row/digit strobing and channel selection, replacing the fixed combinational 2-to-4 decode where a registered or time-multiplexed select is needed.

---
 rtl/scan_decoder_pkg.sv | 19 +
 rtl/scan_decoder_onehot_dec.sv | 21 ++
 rtl/scan_decoder.sv | 129 ++++++++++++
 tb/tb_scan_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_decoder_pkg
// Shared types and constants for the scan_decoder block.
//   state_e     : controller states (IDLE, DIRECT, SCAN)
//   MODE_DIRECT : value of the mode input that selects direct decoding
//   MODE_SCAN   : value of the mode input that selects autonomous scanning
// ---------------------------------------------------------------------------
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
// Purely combinational N-to-2^N one-hot decoder.
//   idx : input  [N-1:0]      binary index
//   y   : output [2^N-1:0]    one-hot value with bit idx set
// ---------------------------------------------------------------------------
module onehot_dec #(
   parameter int N = 2
) (
   input  logic [N-1:0]      idx,
   output logic [(1<<N)-1:0] y
);

   // NOTE: every variable written in an always_comb gets a default first,
   // so no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      y      = '0;
      y[idx] = 1'b1;
   end

endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// Registered N-to-2^N one-hot decoder with two modes: direct decode of a
// presented select value, or an autonomous scan that walks the one-hot
// output across all lines, holding each one for DWELL cycles.
//   clk       : input           rising-edge clock
//   rst       : input           asynchronous reset, active-high
//   en        : input           block enable; 0 forces IDLE
//   mode      : input           0 = direct decode, 1 = scan
//   sel       : input  [N-1:0]  select value for direct mode
//   sel_valid : input           sel is presented this cycle (direct mode)
//   y         : output [2^N-1:0] registered one-hot output (or all-zero)
//   y_valid   : output          y is meaningful this cycle
//   scan_idx  : output [N-1:0]  index of the asserted line in scan mode
//   wrap      : output          one-cycle pulse when scan_idx wraps to 0
// ---------------------------------------------------------------------------
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter  int N     = 2,
   parameter  int DWELL = 4,
   localparam int DW    = $clog2(DWELL + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [N-1:0]      sel,
   input  logic              sel_valid,
   output logic [(1<<N)-1:0] y,
   output logic              y_valid,
   output logic [N-1:0]      scan_idx,
   output logic              wrap
);

   localparam int          NW         = 1 << N;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};

   state_e          state_q, state_d;
   logic [NW-1:0]   y_q, y_d;
   logic            y_valid_q, y_valid_d;
   logic [N-1:0]    scan_idx_q, scan_idx_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic            wrap_q, wrap_d;

   logic [N-1:0]    dec_in;
   logic [NW-1:0]   dec_y;

   // Next state and scan counters. Everything is derived from the state we
   // are about to enter, so the registered outputs line up with that state.
   always_comb begin
      state_d    = IDLE;
      scan_idx_d = '0;
      dwell_d    = '0;
      wrap_d     = 1'b0;

      if (en) begin
         state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
      end

      // Only a continuing scan advances; entering SCAN starts from index 0.
      if (state_d == SCAN && state_q == SCAN) begin
         if (dwell_q == DWELL_LAST) begin
            scan_idx_d = scan_idx_q + 1'b1;
            wrap_d     = (scan_idx_q == IDX_LAST);
         end else begin
            scan_idx_d = scan_idx_q;
            dwell_d    = dwell_q + 1'b1;
         end
      end
   end

   // A single decoder serves both modes: scan index while scanning, else sel.
   assign dec_in = (state_d == SCAN) ? scan_idx_d : sel;

   onehot_dec #(.N(N)) u_dec (
      .idx (dec_in),
      .y   (dec_y)
   );

   always_comb begin
      y_d       = '0;
      y_valid_d = 1'b0;

      unique case (state_d)
         DIRECT: begin
            if (sel_valid) begin
               y_d       = dec_y;
               y_valid_d = 1'b1;
            end else if (state_q == DIRECT) begin
               // Hold the last accepted value; a fresh entry shows zero.
               y_d = y_q;
            end
         end
         SCAN: begin
            y_d       = dec_y;
            y_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         scan_idx_q <= '0;
         dwell_q    <= '0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         scan_idx_q <= scan_idx_d;
         dwell_q    <= dwell_d;
         wrap_q     <= wrap_d;
      end
   end

   assign y        = y_q;
   assign y_valid  = y_valid_q;
   assign scan_idx = scan_idx_q;
   assign wrap     = wrap_q;

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
// Self-checking bench for scan_decoder. Instance A uses N=2, DWELL=3;
// instance B uses N=3, DWELL=1. Expected values are pushed to a queue as
// each cycle's stimulus is driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

   logic       clk = 1'b0;
   logic       rst;

   logic       en_a, mode_a, sv_a;
   logic [1:0] sel_a;
   logic [3:0] y_a;
   logic       yv_a, wrap_a;
   logic [1:0] idx_a;

   logic       en_b, mode_b, sv_b;
   logic [2:0] sel_b;
   logic [7:0] y_b;
   logic       yv_b, wrap_b;
   logic [2:0] idx_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       en;
      logic       mode;
      logic       sv;
      logic [1:0] sel;
      logic [3:0] y;
      logic       yv;
      logic [1:0] idx;
      logic       w;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic       yv;
      logic [2:0] idx;
      logic       w;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   scan_decoder #(.N(2), .DWELL(3)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .en        (en_a),
      .mode      (mode_a),
      .sel       (sel_a),
      .sel_valid (sv_a),
      .y         (y_a),
      .y_valid   (yv_a),
      .scan_idx  (idx_a),
      .wrap      (wrap_a)
   );

   scan_decoder #(.N(3), .DWELL(1)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .en        (en_b),
      .mode      (mode_b),
      .sel       (sel_b),
      .sel_valid (sv_b),
      .y         (y_b),
      .y_valid   (yv_b),
      .scan_idx  (idx_b),
      .wrap      (wrap_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, req);
      end
   endtask

   // y of either instance must be all-zero or exactly one-hot on every cycle.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("onehot_a", 32'($onehot0(y_a)), 32'd1);
         check("onehot_b", 32'($onehot0(y_b)), 32'd1);
      end
   end

   // One cycle on instance A: drive at negedge, queue expectation, sample #1
   // after the next rising edge.
   task automatic step_a(input string tag, input vec_t v);
      exp_t e;
      @(negedge clk);
      en_a   = v.en;
      mode_a = v.mode;
      sv_a   = v.sv;
      sel_a  = v.sel;
      exp_q.push_back('{y: {4'b0, v.y}, yv: v.yv, idx: {1'b0, v.idx}, w: v.w});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, ".y"},     32'(y_a),    32'(e.y));
      check({tag, ".yv"},    32'(yv_a),   32'(e.yv));
      check({tag, ".idx"},   32'(idx_a),  32'(e.idx));
      check({tag, ".wrap"},  32'(wrap_a), 32'(e.w));
   endtask

   // Expected values for the c-th cycle since SCAN entry on instance A.
   function automatic vec_t scan_vec(input int c);
      vec_t v;
      int   k;
      k      = (c / 3) % 4;
      v.en   = 1'b1;
      v.mode = 1'b1;
      v.sv   = 1'b0;
      v.sel  = 2'd3;
      v.y    = 4'b0001 << k;
      v.yv   = 1'b1;
      v.idx  = 2'(k);
      v.w    = (c > 0) && (c % 12 == 0);
      return v;
   endfunction

   function automatic vec_t idle_vec();
      vec_t v;
      v = '{en: 1'b0, mode: 1'b1, sv: 1'b1, sel: 2'd2, y: 4'b0, yv: 1'b0, idx: 2'd0, w: 1'b0};
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t dir_tab[6];
      exp_t e;

      dir_tab[0] = '{en: 1, mode: 0, sv: 0, sel: 2'd2, y: 4'b0000, yv: 0, idx: 0, w: 0};
      dir_tab[1] = '{en: 1, mode: 0, sv: 1, sel: 2'd0, y: 4'b0001, yv: 1, idx: 0, w: 0};
      dir_tab[2] = '{en: 1, mode: 0, sv: 1, sel: 2'd1, y: 4'b0010, yv: 1, idx: 0, w: 0};
      dir_tab[3] = '{en: 1, mode: 0, sv: 1, sel: 2'd2, y: 4'b0100, yv: 1, idx: 0, w: 0};
      dir_tab[4] = '{en: 1, mode: 0, sv: 1, sel: 2'd3, y: 4'b1000, yv: 1, idx: 0, w: 0};
      dir_tab[5] = '{en: 1, mode: 0, sv: 0, sel: 2'd1, y: 4'b1000, yv: 0, idx: 0, w: 0};

      rst  = 1'b1;
      en_a = 1'b0; mode_a = 1'b0; sv_a = 1'b0; sel_a = '0;
      en_b = 1'b0; mode_b = 1'b0; sv_b = 1'b0; sel_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.y",    32'(y_a),    32'd0);
      check("reset.yv",   32'(yv_a),   32'd0);
      check("reset.idx",  32'(idx_a),  32'd0);
      check("reset.wrap", 32'(wrap_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Idle ignores sel and sel_valid.
      step_a("idle0", idle_vec());

      // Direct decode table.
      for (int i = 0; i < 6; i++) step_a($sformatf("direct%0d", i), dir_tab[i]);
      step_a("idle1", idle_vec());

      // Scan with wrap: 14 cycles.
      for (int c = 0; c < 14; c++) step_a($sformatf("scan%0d", c), scan_vec(c));

      // Mode switch while y = 0100, then back to scan with a full dwell.
      step_a("idle2", idle_vec());
      for (int c = 0; c < 7; c++) step_a($sformatf("msw_scan%0d", c), scan_vec(c));
      step_a("msw_direct", '{en: 1, mode: 0, sv: 0, sel: 2'd3, y: 4'b0000, yv: 0, idx: 0, w: 0});
      for (int c = 0; c < 4; c++) step_a($sformatf("msw_rescan%0d", c), scan_vec(c));

      // en drop while y = 0010 for two cycles; scan restarts at 0001.
      step_a("idle3", idle_vec());
      for (int c = 0; c < 4; c++) step_a($sformatf("endrop_scan%0d", c), scan_vec(c));
      step_a("endrop_gap0", idle_vec());
      step_a("endrop_gap1", idle_vec());
      for (int c = 0; c < 5; c++) step_a($sformatf("endrop_rescan%0d", c), scan_vec(c));

      // Asynchronous reset between edges while scanning with outputs active.
      #2;
      rst = 1'b1;
      #1;
      check("areset.y",    32'(y_a),    32'd0);
      check("areset.yv",   32'(yv_a),   32'd0);
      check("areset.idx",  32'(idx_a),  32'd0);
      check("areset.wrap", 32'(wrap_a), 32'd0);
      @(negedge clk);
      en_a = 1'b0;
      rst  = 1'b0;
      // After reset release the scan restarts from index 0.
      for (int c = 0; c < 4; c++) step_a($sformatf("post_rst%0d", c), scan_vec(c));
      step_a("idle4", idle_vec());

      // Instance B: N=3, DWELL=1, 17 cycles of scan.
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         en_b   = 1'b1;
         mode_b = 1'b1;
         sv_b   = 1'b1;
         sel_b  = 3'd5;
         exp_q.push_back('{y: 8'b0000_0001 << (c % 8), yv: 1'b1, idx: 3'(c % 8),
                           w: (c == 8) || (c == 16)});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("d1_scan%0d.y", c),    32'(y_b),    32'(e.y));
         check($sformatf("d1_scan%0d.yv", c),   32'(yv_b),   32'(e.yv));
         check($sformatf("d1_scan%0d.idx", c),  32'(idx_b),  32'(e.idx));
         check($sformatf("d1_scan%0d.wrap", c), 32'(wrap_b), 32'(e.w));
      end
      @(negedge clk);
      en_b = 1'b0;
      @(posedge clk);
      #1;
      check("d1_idle.y", 32'(y_b), 32'd0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_scan_decoder
